v8x3_prio_encoder: RTL and testbench
====================================

// Module: v8x3_prio_encoder
// PURPOSE
//  Registered 8-to-3 priority encoder with request latching and a VALID/ACK
//  handshake; the encode-side counterpart of the 3x8 decoder tree. Captures
//  active-low request edges on I_L[7:0], queues them as pending bits, and
//  presents the highest-priority pending index (7 = highest) until acknowledged.
//  74x148-style GS_L/EO_L status allows cascading to 16 or more lines.
// PARAMETERS
//  SYNC_STAGES  2  synchronizer flops per I_L bit (legal range 1..3)
// PORTS
//  CLK      in   1  single clock; all state updates on rising edge
//  RESET_L  in   1  asynchronous, active-low reset
//  I_L      in   8  request lines, active low, asynchronous to CLK
//  EI_L     in   1  enable input, active low; high blocks new grants
//  ACK      in   1  consumer accepts presented code (sampled only when VALID=1)
//  A        out  3  encoded index of presented request (active high)
//  VALID    out  1  A holds a valid, stable code
//  GS_L     out  1  low when any pending bit set and EI_L low
//  EO_L     out  1  low when EI_L low and no pending bit set (cascade enable)
//  OVR      out  1  one-cycle pulse: request edge on an already pending bit
// BEHAVIOUR
//  Reset (RESET_L=0, immediate): sync flops=all 1s (idle), pending=0, state=IDLE,
//   A=0, VALID=0, GS_L=1, EO_L=1, OVR=0. Reset mid-handshake discards everything.
//  Capture: sI_L = I_L after SYNC_STAGES flops; prev register holds last sI_L.
//   rise[i] = prev[i] & ~sI_L[i] (assertion edge). Level-held low lines
//   produce one request only. I_L edge -> pending bit set: SYNC_STAGES+1 clocks.
//  Pending update per bit, same cycle: set on rise[i]; clear on accepted ACK
//   when i==A; set and clear together -> bit stays set (set wins).
//  OVR=1 for one cycle when rise[i] & pending[i] & ~(accepted ACK clearing i).
//  FSM (registered outputs):
//   IDLE:    VALID=0. If EI_L=0 and pending!=0: A<=highest set index of pending,
//            -> PRESENT (VALID=1 one clock after pending visible).
//   PRESENT: VALID=1, A frozen; new requests (incl. higher priority) only queue.
//            ACK=1 -> clear pending[A], -> GAP. EI_L rising here does NOT abort.
//   GAP:     VALID=0 for exactly one cycle, A holds, -> IDLE.
//  Back-to-back: ACK in cycle n, VALID low in n+1, next VALID earliest n+2.
//  ACK while VALID=0 is ignored. ACK held high continuously: each grant lasts
//   one cycle, separated by the GAP cycle.
//  GS_L/EO_L registered from next-state pending and EI_L: GS_L=~(~EI_L & |pending),
//   EO_L=~(~EI_L & ~|pending); EI_L=1 -> GS_L=1, EO_L=1.
//  State encoding: 2 bits; unused code -> IDLE next cycle.
// TESTING
//  1. Reset, I_L=8'hFF, EI_L=0 -> VALID=0, GS_L=1, EO_L=0, OVR=0 indefinitely.
//  2. Pulse I_L[5] low 1 cycle -> VALID=1, A=3'd5 at SYNC_STAGES+2 clocks;
//     ACK 1 cycle -> VALID=0 next cycle, EO_L=0, GS_L=1.
//  3. I_L[1],I_L[6] fall same cycle -> A=6 first; ACK -> GAP -> A=1; ACK -> idle.
//  4. While A=2 presented, I_L[7] falls -> A stays 2 until ACK; then A=7.
//  5. I_L[3] second fall while pending[3] set -> OVR pulse 1 cycle, single grant;
//     fall coinciding with ACK of index 3 -> no OVR, bit re-granted after GAP.
//  6. EI_L=1 with pending=8'h10 -> no VALID, GS_L=1, EO_L=1; EI_L=0 -> A=4;
//     RESET_L low mid-PRESENT -> all outputs to reset values immediately.

Source files
------------

// File: rtl/v8x3_prio_encoder.sv
// Registered 8-to-3 priority encoder: synchronizes active-low request edges, queues them
// as pending bits and presents the highest pending index through a VALID/ACK handshake.
module v8x3_prio_encoder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RESET_L,
    input  logic [7:0] I_L,
    input  logic       EI_L,
    input  logic       ACK,
    output logic [2:0] A,
    output logic       VALID,
    output logic       GS_L,
    output logic       EO_L,
    output logic       OVR
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2
    } state_t;

    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] sync_d [SYNC_STAGES];
    logic [7:0] prev_q, prev_d;
    logic [7:0] pending_q, pending_d;
    state_t     state_q, state_d;
    logic [2:0] a_q, a_d;
    logic       valid_q, valid_d;
    logic       gs_l_q, gs_l_d;
    logic       eo_l_q, eo_l_d;
    logic       ovr_q, ovr_d;

    logic [7:0] s_i_l;
    logic [7:0] rise;
    logic [7:0] clr;
    logic       ack_acc;

    function automatic logic [2:0] highest_index(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) r = i[2:0];
        end
        return r;
    endfunction

    always_comb begin
        sync_d[0] = I_L;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign s_i_l = sync_q[SYNC_STAGES-1];

    // A request is a high-to-low transition of the synchronized line; held-low lines count once.
    always_comb begin
        prev_d    = s_i_l;
        rise      = prev_q & ~s_i_l;
        ack_acc   = (state_q == PRESENT) && ACK;
        clr       = ack_acc ? (8'h01 << a_q) : 8'h00;
        pending_d = (pending_q & ~clr) | rise;
        ovr_d     = |(rise & pending_q & ~clr);
        gs_l_d    = ~(~EI_L & (|pending_d));
        eo_l_d    = ~(~EI_L & ~(|pending_d));
    end

    // GAP falls through to the grant decision so the next VALID can follow one idle cycle.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        case (state_q)
            IDLE, GAP: begin
                state_d = IDLE;
                if (!EI_L && (pending_q != 8'h00)) begin
                    a_d     = highest_index(pending_q);
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (ACK) state_d = GAP;
            end
            default: state_d = IDLE;
        endcase
        valid_d = (state_d == PRESENT);
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 8'hFF;
            end
            prev_q    <= 8'hFF;
            pending_q <= 8'h00;
            state_q   <= IDLE;
            a_q       <= 3'd0;
            valid_q   <= 1'b0;
            gs_l_q    <= 1'b1;
            eo_l_q    <= 1'b1;
            ovr_q     <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            prev_q    <= prev_d;
            pending_q <= pending_d;
            state_q   <= state_d;
            a_q       <= a_d;
            valid_q   <= valid_d;
            gs_l_q    <= gs_l_d;
            eo_l_q    <= eo_l_d;
            ovr_q     <= ovr_d;
        end
    end

    assign A     = a_q;
    assign VALID = valid_q;
    assign GS_L  = gs_l_q;
    assign EO_L  = eo_l_q;
    assign OVR   = ovr_q;

endmodule

// File: tb/tb_v8x3_prio_encoder.sv
// Self-checking bench for v8x3_prio_encoder: expected grant indices are queued when
// requests are driven and popped when VALID is observed.
module tb_v8x3_prio_encoder;

    localparam int SS = 2;

    logic       CLK;
    logic       RESET_L;
    logic [7:0] I_L;
    logic       EI_L;
    logic       ACK;
    logic [2:0] A;
    logic       VALID;
    logic       GS_L;
    logic       EO_L;
    logic       OVR;

    int         n_cmp;
    int         n_bad;
    logic [2:0] exp_q[$];
    logic [2:0] exp_a;
    bit         got;

    v8x3_prio_encoder #(.SYNC_STAGES(SS)) dut (
        .CLK(CLK), .RESET_L(RESET_L), .I_L(I_L), .EI_L(EI_L), .ACK(ACK),
        .A(A), .VALID(VALID), .GS_L(GS_L), .EO_L(EO_L), .OVR(OVR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_lines(input logic [7:0] mask);
        I_L = ~mask;
        step();
        I_L = 8'hFF;
    endtask

    task automatic wait_valid(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            step();
            if (VALID === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic do_ack();
        ACK = 1'b1;
        step();
        ACK = 1'b0;
    endtask

    task automatic test_reset();
        RESET_L = 1'b1; I_L = 8'hFF; EI_L = 1'b0; ACK = 1'b0;
        #2 RESET_L = 1'b0;
        #2;
        n_cmp++;
        if ({A, VALID, GS_L, EO_L, OVR} !== {3'd0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL reset_values: A/V/GS/EO/OVR=%0d/%0b/%0b/%0b/%0b required 0/0/1/1/0",
                     A, VALID, GS_L, EO_L, OVR);
        end
        step(); step();
        RESET_L = 1'b1;
    endtask

    task automatic test_idle();
        for (int k = 0; k < 5; k++) begin
            step();
            n_cmp++;
            if ({VALID, GS_L, EO_L, OVR} !== 4'b0100) begin
                n_bad++;
                $display("[TB] FAIL idle_status: V/GS/EO/OVR=%0b/%0b/%0b/%0b required 0/1/0/0",
                         VALID, GS_L, EO_L, OVR);
            end
        end
    endtask

    task automatic test_single();
        exp_q.push_back(3'd5);
        I_L = ~8'h20;
        for (int k = 1; k <= SS + 2; k++) begin
            step();
            if (k == 1) I_L = 8'hFF;
            n_cmp++;
            if (VALID !== (k == SS + 2)) begin
                n_bad++;
                $display("[TB] FAIL single_latency: clock %0d VALID=%0b required %0b", k, VALID, (k == SS + 2));
            end
        end
        if (VALID === 1'b1) begin
            exp_a = exp_q.pop_front();
            n_cmp++;
            if (A !== exp_a || GS_L !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL single_grant: A=%0d GS_L=%0b required A=%0d GS_L=0", A, GS_L, exp_a);
            end
        end
        do_ack();
        n_cmp++;
        if ({VALID, GS_L, EO_L} !== 3'b010) begin
            n_bad++;
            $display("[TB] FAIL single_ack: V/GS/EO=%0b/%0b/%0b required 0/1/0", VALID, GS_L, EO_L);
        end
    endtask

    task automatic test_priority();
        exp_q.push_back(3'd6);
        exp_q.push_back(3'd1);
        pulse_lines(8'h42);
        for (int g = 0; g < 2; g++) begin
            wait_valid(got);
            n_cmp++;
            if (!got || exp_q.size() == 0) begin
                n_bad++;
                $display("[TB] FAIL prio_grant%0d: VALID=%0b queued=%0d required VALID=1", g, VALID, exp_q.size());
            end else begin
                exp_a = exp_q.pop_front();
                if (A !== exp_a) begin
                    n_bad++;
                    $display("[TB] FAIL prio_grant%0d: A=%0d required %0d", g, A, exp_a);
                end
            end
            do_ack();
            n_cmp++;
            if (VALID !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL prio_gap%0d: VALID=%0b required 0", g, VALID);
            end
        end
        step();
        n_cmp++;
        if (VALID !== 1'b0 || EO_L !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL prio_idle: VALID=%0b EO_L=%0b required 0/0", VALID, EO_L);
        end
    endtask

    task automatic test_no_preempt();
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd7);
        pulse_lines(8'h04);
        wait_valid(got);
        n_cmp++;
        if (!got || A !== exp_q[0]) begin
            n_bad++;
            $display("[TB] FAIL preempt_first: VALID=%0b A=%0d required 1/2", VALID, A);
        end
        if (got) exp_a = exp_q.pop_front();
        pulse_lines(8'h80);
        for (int k = 0; k < SS + 2; k++) begin
            step();
            n_cmp++;
            if (VALID !== 1'b1 || A !== 3'd2) begin
                n_bad++;
                $display("[TB] FAIL preempt_hold: VALID=%0b A=%0d required 1/2", VALID, A);
            end
        end
        do_ack();
        wait_valid(got);
        n_cmp++;
        if (!got || exp_q.size() == 0) begin
            n_bad++;
            $display("[TB] FAIL preempt_second: VALID=%0b queued=%0d required VALID=1", VALID, exp_q.size());
        end else begin
            exp_a = exp_q.pop_front();
            if (A !== exp_a) begin
                n_bad++;
                $display("[TB] FAIL preempt_second: A=%0d required %0d", A, exp_a);
            end
        end
        do_ack();
    endtask

    task automatic test_overrun();
        exp_q.push_back(3'd3);
        pulse_lines(8'h08);
        wait_valid(got);
        n_cmp++;
        if (!got || A !== exp_q[0]) begin
            n_bad++;
            $display("[TB] FAIL ovr_grant: VALID=%0b A=%0d required 1/3", VALID, A);
        end
        if (got) exp_a = exp_q.pop_front();
        pulse_lines(8'h08);
        for (int k = 2; k <= SS + 3; k++) begin
            step();
            n_cmp++;
            if (OVR !== (k == SS + 1) || VALID !== 1'b1) begin
                n_bad++;
                $display("[TB] FAIL ovr_pulse: clock %0d OVR=%0b VALID=%0b required %0b/1", k, OVR, VALID, (k == SS + 1));
            end
        end
        do_ack();
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++;
            if (VALID !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL ovr_single_grant: VALID=%0b required 0", VALID);
            end
        end
        exp_q.push_back(3'd3);
        pulse_lines(8'h08);
        wait_valid(got);
        if (got) exp_a = exp_q.pop_front();
        exp_q.push_back(3'd3);
        I_L = ~8'h08;
        step();
        I_L = 8'hFF;
        for (int k = 2; k <= SS; k++) step();
        do_ack();
        n_cmp++;
        if (OVR !== 1'b0 || VALID !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL ovr_ack_collide: OVR=%0b VALID=%0b required 0/0", OVR, VALID);
        end
        wait_valid(got);
        n_cmp++;
        if (!got || exp_q.size() == 0) begin
            n_bad++;
            $display("[TB] FAIL ovr_regrant: VALID=%0b queued=%0d required VALID=1", VALID, exp_q.size());
        end else begin
            exp_a = exp_q.pop_front();
            if (A !== exp_a) begin
                n_bad++;
                $display("[TB] FAIL ovr_regrant: A=%0d required %0d", A, exp_a);
            end
        end
        do_ack();
    endtask

    task automatic test_back_to_back();
        logic       exp_v [4];
        logic [2:0] exp_av [4];
        exp_v  = '{1'b0, 1'b1, 1'b0, 1'b0};
        exp_av = '{3'd7, 3'd0, 3'd0, 3'd0};
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd0);
        pulse_lines(8'h81);
        wait_valid(got);
        n_cmp++;
        if (!got || A !== exp_q[0]) begin
            n_bad++;
            $display("[TB] FAIL b2b_first: VALID=%0b A=%0d required 1/7", VALID, A);
        end
        if (got) exp_a = exp_q.pop_front();
        ACK = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            if (exp_v[k] && VALID === 1'b1 && exp_q.size() != 0) exp_a = exp_q.pop_front();
            n_cmp++;
            if (VALID !== exp_v[k] || A !== exp_av[k]) begin
                n_bad++;
                $display("[TB] FAIL b2b_cycle%0d: VALID=%0b A=%0d required %0b/%0d", k, VALID, A, exp_v[k], exp_av[k]);
            end
        end
        ACK = 1'b0;
    endtask

    task automatic test_enable_reset();
        EI_L = 1'b1;
        exp_q.push_back(3'd4);
        pulse_lines(8'h10);
        for (int k = 0; k < SS + 4; k++) begin
            step();
            n_cmp++;
            if ({VALID, GS_L, EO_L} !== 3'b011) begin
                n_bad++;
                $display("[TB] FAIL enable_block: V/GS/EO=%0b/%0b/%0b required 0/1/1", VALID, GS_L, EO_L);
            end
        end
        EI_L = 1'b0;
        wait_valid(got);
        n_cmp++;
        if (!got || exp_q.size() == 0) begin
            n_bad++;
            $display("[TB] FAIL enable_grant: VALID=%0b queued=%0d required VALID=1", VALID, exp_q.size());
        end else begin
            exp_a = exp_q.pop_front();
            if (A !== exp_a || GS_L !== 1'b0 || EO_L !== 1'b1) begin
                n_bad++;
                $display("[TB] FAIL enable_grant: A=%0d GS_L=%0b EO_L=%0b required %0d/0/1", A, GS_L, EO_L, exp_a);
            end
        end
        #2 RESET_L = 1'b0;
        #1;
        n_cmp++;
        if ({A, VALID, GS_L, EO_L, OVR} !== {3'd0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL reset_mid_present: A/V/GS/EO/OVR=%0d/%0b/%0b/%0b/%0b required 0/0/1/1/0",
                     A, VALID, GS_L, EO_L, OVR);
        end
        step();
        RESET_L = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            n_cmp++;
            if (VALID !== 1'b0 || GS_L !== 1'b1) begin
                n_bad++;
                $display("[TB] FAIL reset_discard: VALID=%0b GS_L=%0b required 0/1", VALID, GS_L);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_idle();
        test_single();
        test_priority();
        test_no_preempt();
        test_overrun();
        test_back_to_back();
        test_enable_reset();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
